// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready handshake backed by a main + skid register pair,
// synchronous flush to a bubble pattern, and a saturating downstream-stall counter.
module pipe_stage_elastic #(
    parameter int          DATA_W = 32,
    parameter logic [31:0] BUBBLE = 32'h00000033,
    parameter int          CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Zero-extend then truncate so any DATA_W gets a well-defined bubble.
    localparam logic [DATA_W+31:0] BUB_EXT = {{DATA_W{1'b0}}, BUBBLE};
    localparam logic [DATA_W-1:0]  BUB     = BUB_EXT[DATA_W-1:0];

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_q, main_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                in_fire, out_fire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) return v;
        return v + 1'b1;
    endfunction

    always_comb begin
        in_ready  = (state_q != FULL) && !flush;
        out_valid = (state_q != EMPTY);
        out_data  = out_valid ? main_q : BUB;
        occupancy = (state_q == FULL) ? 2'd2 : ((state_q == ONE) ? 2'd1 : 2'd0);
        stall_cnt = cnt_q;
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = (out_valid && !out_ready) ? sat_inc(cnt_q) : cnt_q;

        if (flush) begin
            state_d = EMPTY;
            main_d  = BUB;
            skid_d  = BUB;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain path exists.
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= BUB;
            skid_q  <= BUB;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: reset, streaming, back-pressure, flush,
// simultaneous fire in ONE, and stall-counter saturation on a narrow-counter instance.
module tb_pipe_stage_elastic;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [31:0] in_data = '0, out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        s_rst = 1'b1, s_flush = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_in_data = '0, s_out_data;
    logic [1:0]  s_occupancy;
    logic [3:0]  s_stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_stage_elastic #(.DATA_W(32), .BUBBLE(32'h00000033), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_elastic #(.DATA_W(32), .BUBBLE(32'h00000033), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(s_rst), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
        step(); step();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_tests++; if (out_data !== 32'h33) begin n_fail++; $display("FAIL reset_out_data got %h want 00000033", out_data); end
        n_tests++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 32'(i);
            step();
            n_tests++; if (out_data !== 32'(i) || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL stream_data[%0d] got %h/%0b want %h/1", i, out_data, out_valid, i);
            end
            n_tests++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d] got %0d want 1", i, occupancy); end
        end
        in_valid = 1'b0;
        step();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got %0b want 0", out_valid); end
        n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL stream_stall_cnt got %0d want 0", stall_cnt); end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        step();
        n_tests++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_one got occ %0d rdy %0b want occ 1 rdy 1", occupancy, in_ready);
        end
        in_data = 32'hB;
        step();
        in_valid = 1'b0;
        #1;
        n_tests++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_occ got %0d want 2", occupancy); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %0b want 0", in_ready); end
        n_tests++; if (out_data !== 32'hA) begin n_fail++; $display("FAIL bp_head got %h want 0000000a", out_data); end
        n_tests++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL bp_cnt1 got %0d want 1", stall_cnt); end
        step(); step();
        n_tests++; if (stall_cnt !== 16'd3 || out_data !== 32'hA) begin
            n_fail++; $display("FAIL bp_cnt3 got cnt %0d data %h want cnt 3 data 0000000a", stall_cnt, out_data);
        end
        out_ready = 1'b1;
        step();
        n_tests++; if (out_data !== 32'hB || occupancy !== 2'd1) begin
            n_fail++; $display("FAIL bp_second got %h occ %0d want 0000000b occ 1", out_data, occupancy);
        end
        step();
        n_tests++; if (out_valid !== 1'b0 || out_data !== 32'h33) begin
            n_fail++; $display("FAIL bp_empty got %0b/%h want 0/00000033", out_valid, out_data);
        end
        n_tests++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL bp_cnt_hold got %0d want 3", stall_cnt); end
    endtask

    task automatic test_flush_full();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        step();
        in_data = 32'hB;
        step();
        in_data = 32'hC; flush = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %0b want 0", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_tests++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_occ got %0d/%0b want 0/0", occupancy, out_valid);
        end
        n_tests++; if (out_data !== 32'h33) begin n_fail++; $display("FAIL flush_bubble got %h want 00000033", out_data); end
        n_tests++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL flush_cnt got %0d want 5", stall_cnt); end
        step();
        n_tests++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_c_dropped got occ %0d want 0", occupancy); end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h100;
        step();
        for (int i = 1; i <= 4; i++) begin
            in_data = 32'h100 + 32'(i);
            step();
            n_tests++; if (out_data !== 32'h100 + 32'(i) || occupancy !== 2'd1) begin
                n_fail++; $display("FAIL simul[%0d] got %h occ %0d want %h occ 1", i, out_data, occupancy, 32'h100 + 32'(i));
            end
        end
        in_valid = 1'b0;
        step();
        n_tests++; if (out_valid !== 1'b0 || stall_cnt !== 16'd5) begin
            n_fail++; $display("FAIL simul_end got %0b cnt %0d want 0 cnt 5", out_valid, stall_cnt);
        end
    endtask

    task automatic test_saturation();
        s_rst = 1'b1;
        step();
        s_rst = 1'b0; s_out_ready = 1'b0; s_in_valid = 1'b1; s_in_data = 32'h7;
        step();
        s_in_valid = 1'b0;
        repeat (10) step();
        n_tests++; if (s_stall_cnt !== 4'd10) begin n_fail++; $display("FAIL sat_mid got %0d want 10", s_stall_cnt); end
        repeat (10) step();
        n_tests++; if (s_stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_top got %0d want 15", s_stall_cnt); end
        n_tests++; if (s_out_data !== 32'h7) begin n_fail++; $display("FAIL sat_hold got %h want 00000007", s_out_data); end
        s_rst = 1'b1;
        step();
        s_rst = 1'b0;
        #1;
        n_tests++; if (s_stall_cnt !== 4'd0 || s_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL sat_rst got cnt %0d vld %0b want 0/0", s_stall_cnt, s_out_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush_full();
        test_simultaneous();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
